// File: rtl/tia_pkg.sv
// Shared constants, types and helpers for the TIA object position/motion path.
package tia_pkg;

    localparam int SCREEN_W   = 160;
    localparam int LINE_W     = 228;
    localparam int HBLANK_POS = 3;

    typedef logic signed [3:0] hm_val_t;

    // Neighbour of pos on the wrapping line: dir=1 moves right (+1), dir=0 moves left (-1).
    function automatic logic [7:0] wrap_step(input logic [7:0] pos, input logic dir,
                                             input logic [8:0] modulus);
        logic [8:0] sum;
        if (dir) begin
            sum = {1'b0, pos} + 9'd1;
        end else begin
            sum = {1'b0, pos} + modulus - 9'd1;
        end
        if (sum >= modulus) begin
            sum = sum - modulus;
        end else begin
            sum = sum;
        end
        return sum[7:0];
    endfunction

    // Magnitude of a motion value, 0..8 (-8 maps to 8 without overflow).
    function automatic logic [3:0] motion_mag(input hm_val_t hm);
        logic [3:0] mag;
        if (hm[3]) begin
            mag = (~hm) + 4'd1;
        end else begin
            mag = hm;
        end
        return mag;
    endfunction

endpackage

// File: rtl/tia_obj_motion.sv
// Per-object horizontal position register with RESP load, HM motion register
// and one-pixel-per-clock HMOVE stepping.
module tia_obj_motion
    import tia_pkg::*;
#(
    parameter int SCREEN_W    = tia_pkg::SCREEN_W,
    parameter int HBLANK_POS  = tia_pkg::HBLANK_POS,
    parameter int RESP_OFFSET = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pixel_num,
    input  logic       resp,
    input  logic       hm_wr,
    input  logic [3:0] hm_data,
    input  logic       hmclr,
    input  logic       hmove,
    output logic [7:0] obj_pos,
    output logic [3:0] hm_reg,
    output logic       busy
);

    localparam logic [8:0] SCREEN_W9  = 9'(SCREEN_W);
    localparam logic [9:0] SCREEN_W10 = 10'(SCREEN_W);

    logic [7:0] pos_r;
    hm_val_t    hm_r;
    logic [3:0] cnt_r;
    logic       dir_r;
    logic       busy_r;

    logic [9:0] resp_sum_s;
    logic [9:0] resp_mod_s;
    logic [7:0] resp_pos_s;
    logic [3:0] mag_s;

    // RESP load target and HMOVE step count derived from current inputs/state.
    always_comb begin
        resp_sum_s = 10'(pixel_num) + 10'(RESP_OFFSET);
        resp_mod_s = resp_sum_s % SCREEN_W10;
        if ({1'b0, pixel_num} < SCREEN_W9) begin
            resp_pos_s = resp_mod_s[7:0];
        end else begin
            // hblank, including out-of-contract pixel numbers above the line length
            resp_pos_s = 8'(HBLANK_POS);
        end
        mag_s = motion_mag(hm_r);
    end

    // Motion register, step counter and position state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_r  <= 8'd0;
            hm_r   <= 4'sd0;
            cnt_r  <= 4'd0;
            dir_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            if (hm_wr) begin
                hm_r <= hm_data;
            end else if (hmclr) begin
                hm_r <= 4'sd0;
            end else begin
                hm_r <= hm_r;
            end

            if (resp) begin
                pos_r  <= resp_pos_s;
                cnt_r  <= 4'd0;
                busy_r <= 1'b0;
            end else if (hmove) begin
                // reload discards any remaining steps; the step itself starts next cycle
                cnt_r  <= mag_s;
                dir_r  <= hm_r[3];
                busy_r <= (mag_s != 4'd0);
            end else if (cnt_r != 4'd0) begin
                pos_r  <= wrap_step(pos_r, dir_r, SCREEN_W9);
                cnt_r  <= cnt_r - 4'd1;
                busy_r <= (cnt_r != 4'd1);
            end else begin
                pos_r  <= pos_r;
                cnt_r  <= cnt_r;
                busy_r <= 1'b0;
            end
        end
    end

    assign obj_pos = pos_r;
    assign hm_reg  = hm_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_tia_obj_motion.sv
// Directed scoreboard bench for tia_obj_motion: each driven cycle queues its
// expected post-edge state, which is popped and compared just after the edge.
module tb_tia_obj_motion;

    logic       clk;
    logic       reset;
    logic [7:0] pixel_num;
    logic       resp;
    logic       hm_wr;
    logic [3:0] hm_data;
    logic       hmclr;
    logic       hmove;
    logic [7:0] obj_pos;
    logic [3:0] hm_reg;
    logic       busy;

    typedef struct {
        logic [7:0] pos;
        logic [3:0] hm;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   range_on = 1'b0;

    tia_obj_motion dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_num (pixel_num),
        .resp      (resp),
        .hm_wr     (hm_wr),
        .hm_data   (hm_data),
        .hmclr     (hmclr),
        .hmove     (hmove),
        .obj_pos   (obj_pos),
        .hm_reg    (hm_reg),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        if (obs !== expv) begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Position must stay on the visible line every cycle once out of reset.
    always @(negedge clk) begin
        if (range_on) check_val("range", {15'd0, (obj_pos < 8'd160)}, 16'd1);
    end

    // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
    task automatic cyc(input logic r, input logic rp, input logic [7:0] pix,
                       input logic w, input logic [3:0] d, input logic c, input logic m,
                       input logic [7:0] epos, input logic [3:0] ehm, input logic ebusy,
                       input string tag);
        exp_t e;
        @(negedge clk);
        reset = r; resp = rp; pixel_num = pix;
        hm_wr = w; hm_data = d; hmclr = c; hmove = m;
        e.pos = epos; e.hm = ehm; e.busy = ebusy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".pos"},  {8'd0, obj_pos},  {8'd0, e.pos});
        check_val({tag, ".hm"},   {12'd0, hm_reg},  {12'd0, e.hm});
        check_val({tag, ".busy"}, {15'd0, busy},    {15'd0, e.busy});
    endtask

    task automatic idle(input logic [7:0] epos, input logic [3:0] ehm, input logic ebusy,
                        input string tag);
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, epos, ehm, ebusy, tag);
    endtask

    initial begin
        reset = 1'b1; resp = 1'b0; pixel_num = 8'd0;
        hm_wr = 1'b0; hm_data = 4'd0; hmclr = 1'b0; hmove = 1'b0;

        // reset overrides a simultaneous RESP and HM write
        cyc(1'b1, 1'b1, 8'd40, 1'b1, 4'd5, 1'b0, 1'b1, 8'd0, 4'd0, 1'b0, "rst");
        range_on = 1'b1;

        // RESP in display, then 3 left steps
        cyc(1'b0, 1'b1, 8'd40, 1'b0, 4'd0, 1'b0, 1'b0, 8'd40, 4'd0, 1'b0, "resp40");
        cyc(1'b0, 1'b0, 8'd0,  1'b1, 4'd3, 1'b0, 1'b0, 8'd40, 4'd3, 1'b0, "wr3");
        cyc(1'b0, 1'b0, 8'd0,  1'b0, 4'd0, 1'b0, 1'b1, 8'd40, 4'd3, 1'b1, "hmv3");
        idle(8'd39, 4'd3, 1'b1, "l1");
        idle(8'd38, 4'd3, 1'b1, "l2");
        idle(8'd37, 4'd3, 1'b0, "l3");
        idle(8'd37, 4'd3, 1'b0, "l_done");

        // -8: eight right steps wrapping 159 -> 0
        cyc(1'b0, 1'b1, 8'd155, 1'b0, 4'd0, 1'b0, 1'b0, 8'd155, 4'd3, 1'b0, "resp155");
        cyc(1'b0, 1'b0, 8'd0,   1'b1, 4'd8, 1'b0, 1'b0, 8'd155, 4'd8, 1'b0, "wrm8");
        cyc(1'b0, 1'b0, 8'd0,   1'b0, 4'd0, 1'b0, 1'b1, 8'd155, 4'd8, 1'b1, "hmvm8");
        idle(8'd156, 4'd8, 1'b1, "r1");
        idle(8'd157, 4'd8, 1'b1, "r2");
        idle(8'd158, 4'd8, 1'b1, "r3");
        idle(8'd159, 4'd8, 1'b1, "r4");
        idle(8'd0,   4'd8, 1'b1, "r5wrap");
        idle(8'd1,   4'd8, 1'b1, "r6");
        idle(8'd2,   4'd8, 1'b1, "r7");
        idle(8'd3,   4'd8, 1'b0, "r8");

        // left wrap 0 -> 159
        cyc(1'b0, 1'b1, 8'd1, 1'b0, 4'd0, 1'b0, 1'b0, 8'd1, 4'd8, 1'b0, "resp1");
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd2, 1'b0, 1'b0, 8'd1, 4'd2, 1'b0, "wr2");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd1, 4'd2, 1'b1, "hmv2");
        idle(8'd0,   4'd2, 1'b1, "lw1");
        idle(8'd159, 4'd2, 1'b0, "lw2wrap");

        // RESP in hblank mid-motion, with a same-cycle HMOVE that must lose
        cyc(1'b0, 1'b0, 8'd0,   1'b1, 4'd7, 1'b0, 1'b0, 8'd159, 4'd7, 1'b0, "wr7");
        cyc(1'b0, 1'b0, 8'd0,   1'b0, 4'd0, 1'b0, 1'b1, 8'd159, 4'd7, 1'b1, "hmv7");
        idle(8'd158, 4'd7, 1'b1, "m1");
        cyc(1'b0, 1'b1, 8'd200, 1'b0, 4'd0, 1'b0, 1'b1, 8'd3, 4'd7, 1'b0, "resp200");
        idle(8'd3, 4'd7, 1'b0, "cancelled");

        // hm_wr beats hmclr; later write does not disturb the running move
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd5, 1'b1, 1'b0, 8'd3, 4'd5, 1'b0, "wrclr");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd3, 4'd5, 1'b1, "hmv5");
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'hF, 1'b0, 1'b0, 8'd2, 4'hF, 1'b1, "wrm1");
        idle(8'd1,   4'hF, 1'b1, "s2");
        idle(8'd0,   4'hF, 1'b1, "s3");
        idle(8'd159, 4'hF, 1'b1, "s4");
        idle(8'd158, 4'hF, 1'b0, "s5");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd158, 4'hF, 1'b1, "hmvm1");
        idle(8'd159, 4'hF, 1'b0, "right1");

        // HMCLR alone, then HMOVE with zero motion
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd159, 4'd0, 1'b0, "clr");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd159, 4'd0, 1'b0, "hmv0");
        idle(8'd159, 4'd0, 1'b0, "hmv0_idle");

        // HMOVE while busy reloads from the current motion register
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd3, 1'b0, 1'b0, 8'd159, 4'd3, 1'b0, "wr3b");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd159, 4'd3, 1'b1, "hmv3b");
        idle(8'd158, 4'd3, 1'b1, "rl1");
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd1, 1'b0, 1'b0, 8'd157, 4'd1, 1'b1, "wr1");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd157, 4'd1, 1'b1, "reload");
        idle(8'd156, 4'd1, 1'b0, "rl_done");

        // RESP boundary pixels
        cyc(1'b0, 1'b1, 8'd159, 1'b0, 4'd0, 1'b0, 1'b0, 8'd159, 4'd1, 1'b0, "resp159");
        cyc(1'b0, 1'b1, 8'd160, 1'b0, 4'd0, 1'b0, 1'b0, 8'd3,   4'd1, 1'b0, "resp160");
        cyc(1'b0, 1'b1, 8'd0,   1'b0, 4'd0, 1'b0, 1'b0, 8'd0,   4'd1, 1'b0, "resp0");
        cyc(1'b0, 1'b1, 8'd255, 1'b0, 4'd0, 1'b0, 1'b0, 8'd3,   4'd1, 1'b0, "resp255");

        // synchronous reset mid-motion
        cyc(1'b0, 1'b0, 8'd0, 1'b1, 4'd4, 1'b0, 1'b0, 8'd3, 4'd4, 1'b0, "wr4");
        cyc(1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 8'd3, 4'd4, 1'b1, "hmv4");
        idle(8'd2, 4'd4, 1'b1, "pre_rst");
        cyc(1'b1, 1'b0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 4'd0, 1'b0, "midrst");
        idle(8'd0, 4'd0, 1'b0, "post_rst");

        check_val("queue_empty", 16'(exp_q.size()), 16'd0);
        range_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
